// File: rtl/ysyx_22040895_wb_arbiter.sv
// Write-back arbiter for the integer register file's single write port.
// EXU and LSU write requests each land in a one-entry buffer. A round-robin
// grant (with age ordering for same-register writes) moves one entry per
// cycle into a registered write stage. Read-after-write hazards are reported
// combinationally for the two decode read ports.
module ysyx_22040895_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid_i,
  output logic              exu_ready_o,
  input  logic [ADDR_W-1:0] exu_waddr_i,
  input  logic [DATA_W-1:0] exu_wdata_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_waddr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic              hazard1_o,
  output logic              hazard2_o,
  output logic [1:0]        pending_o
);

  // Identifies which source won the most recent contested grant.
  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  logic              exu_buf_valid;
  logic [ADDR_W-1:0] exu_buf_addr;
  logic [DATA_W-1:0] exu_buf_data;
  logic              lsu_buf_valid;
  logic [ADDR_W-1:0] lsu_buf_addr;
  logic [DATA_W-1:0] lsu_buf_data;
  logic              lsu_older;   // meaningful only while both buffers are valid
  src_e              rr_last;

  logic grant_exu;
  logic grant_lsu;
  logic contested;
  logic exu_fire;
  logic lsu_fire;
  logic exu_load;
  logic lsu_load;

  assign contested = exu_buf_valid & lsu_buf_valid;

  // Grant selection: lone entry wins; same register goes oldest first;
  // otherwise alternate against the last contested winner.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (contested) begin
      if (exu_buf_addr == lsu_buf_addr) begin
        if (lsu_older) grant_lsu = 1'b1;
        else           grant_exu = 1'b1;
      end else if (rr_last == SRC_LSU) begin
        grant_exu = 1'b1;
      end else begin
        grant_lsu = 1'b1;
      end
    end else if (exu_buf_valid) begin
      grant_exu = 1'b1;
    end else if (lsu_buf_valid) begin
      grant_lsu = 1'b1;
    end
  end

  // Ready depends only on buffer state and grant, never on the valid inputs.
  assign exu_ready_o = ~exu_buf_valid | grant_exu;
  assign lsu_ready_o = ~lsu_buf_valid | grant_lsu;

  assign exu_fire = exu_valid_i & exu_ready_o;
  assign lsu_fire = lsu_valid_i & lsu_ready_o;

  // Writes to x0 are accepted but never buffered.
  assign exu_load = exu_fire & (exu_waddr_i != '0);
  assign lsu_load = lsu_fire & (lsu_waddr_i != '0);

  // Buffer occupancy, relative age and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exu_buf_valid <= 1'b0;
      lsu_buf_valid <= 1'b0;
      lsu_older     <= 1'b0;
      rr_last       <= SRC_LSU;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (exu_load)       exu_buf_valid <= 1'b1;
      else if (grant_exu) exu_buf_valid <= 1'b0;

      if (lsu_load)       lsu_buf_valid <= 1'b1;
      else if (grant_lsu) lsu_buf_valid <= 1'b0;

      // A fresh entry is younger than a resident one; on a simultaneous
      // load the LSU entry counts as older.
      if (exu_load)      lsu_older <= 1'b1;
      else if (lsu_load) lsu_older <= 1'b0;

      if (contested) rr_last <= grant_lsu ? SRC_LSU : SRC_EXU;
    end
  end

  // Buffer payload, captured on an accepted nonzero-address request.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; their contents are only ever
    // observed while the matching valid bit (which is reset) is set.
    if (exu_load) begin
      exu_buf_addr <= exu_waddr_i;
      exu_buf_data <= exu_wdata_i;
    end
    if (lsu_load) begin
      lsu_buf_addr <= lsu_waddr_i;
      lsu_buf_data <= lsu_wdata_i;
    end
  end

  // Registered write stage; address and data hold when no grant occurs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else begin
      we_o <= grant_exu | grant_lsu;
      if (grant_exu) begin
        waddr_o <= exu_buf_addr;
        wdata_o <= exu_buf_data;
      end else if (grant_lsu) begin
        waddr_o <= lsu_buf_addr;
        wdata_o <= lsu_buf_data;
      end
    end
  end

  // A read of a nonzero register conflicts with any write still in flight.
  assign hazard1_o = (raddr1_i != '0) &
                     ((exu_buf_valid & (exu_buf_addr == raddr1_i)) |
                      (lsu_buf_valid & (lsu_buf_addr == raddr1_i)) |
                      (we_o & (waddr_o == raddr1_i)));
  assign hazard2_o = (raddr2_i != '0) &
                     ((exu_buf_valid & (exu_buf_addr == raddr2_i)) |
                      (lsu_buf_valid & (lsu_buf_addr == raddr2_i)) |
                      (we_o & (waddr_o == raddr2_i)));

  assign pending_o = 2'(exu_buf_valid) + 2'(lsu_buf_valid) + 2'(we_o);

endmodule

// File: tb/tb_ysyx_22040895_wb_arbiter.sv
// Self-checking bench for the write-back arbiter: a per-cycle vector table
// for single writes, x0 discard, same-register ordering and hazards, plus
// hand-written sequences for sustained contention and mid-stream reset.
module tb_ysyx_22040895_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        exu_valid_i;
  logic        exu_ready_o;
  logic [4:0]  exu_waddr_i;
  logic [63:0] exu_wdata_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_waddr_i;
  logic [63:0] lsu_wdata_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [63:0] wdata_o;
  logic [4:0]  raddr1_i;
  logic [4:0]  raddr2_i;
  logic        hazard1_o;
  logic        hazard2_o;
  logic [1:0]  pending_o;

  int checks = 0;
  int errors = 0;

  ysyx_22040895_wb_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .exu_valid_i (exu_valid_i),
    .exu_ready_o (exu_ready_o),
    .exu_waddr_i (exu_waddr_i),
    .exu_wdata_i (exu_wdata_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_waddr_i (lsu_waddr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .raddr1_i    (raddr1_i),
    .raddr2_i    (raddr2_i),
    .hazard1_o   (hazard1_o),
    .hazard2_o   (hazard2_o),
    .pending_o   (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [4:0]  ea;
    logic [63:0] ed;
    logic        lv;
    logic [4:0]  la;
    logic [63:0] ld;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        x_er;
    logic        x_lr;
    logic        x_we;
    logic [4:0]  x_wa;
    logic [63:0] x_wd;
    logic        x_h1;
    logic        x_h2;
    logic [1:0]  x_pend;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    exu_valid_i = 1'b0;
    exu_waddr_i = '0;
    exu_wdata_i = '0;
    lsu_valid_i = 1'b0;
    lsu_waddr_i = '0;
    lsu_wdata_i = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " we"},      64'(we_o),        64'd0);
    check({tag, " waddr"},   64'(waddr_o),     64'd0);
    check({tag, " wdata"},   wdata_o,          64'd0);
    check({tag, " pending"}, 64'(pending_o),   64'd0);
    check({tag, " hz1"},     64'(hazard1_o),   64'd0);
    check({tag, " hz2"},     64'(hazard2_o),   64'd0);
    check({tag, " eready"},  64'(exu_ready_o), 64'd1);
    check({tag, " lready"},  64'(lsu_ready_o), 64'd1);
  endtask

  initial begin
    // Row N is driven after a falling edge and checked before the next
    // rising edge, so registered outputs reflect all earlier rows.
    //          ev ea   ed           lv la   ld          r1    r2    er lr we wa    wd             h1 h2 pend
    vecs[0]  = '{1, 5'd5, 64'h1234, 0, 5'd0, 64'h0,  5'd5, 5'd0, 1, 1, 0, 5'd0, 64'h0,    0, 0, 2'd0};
    vecs[1]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd5, 5'd0, 1, 1, 0, 5'd0, 64'h0,    1, 0, 2'd1};
    vecs[2]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd5, 5'd0, 1, 1, 1, 5'd5, 64'h1234, 1, 0, 2'd1};
    vecs[3]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd5, 5'd0, 1, 1, 0, 5'd5, 64'h1234, 0, 0, 2'd0};
    vecs[4]  = '{1, 5'd0, 64'hFFFF, 0, 5'd0, 64'h0,  5'd0, 5'd0, 1, 1, 0, 5'd5, 64'h1234, 0, 0, 2'd0};
    vecs[5]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd0, 5'd0, 1, 1, 0, 5'd5, 64'h1234, 0, 0, 2'd0};
    vecs[6]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd0, 5'd0, 1, 1, 0, 5'd5, 64'h1234, 0, 0, 2'd0};
    vecs[7]  = '{1, 5'd9, 64'hA,    1, 5'd9, 64'hB,  5'd9, 5'd9, 1, 1, 0, 5'd5, 64'h1234, 0, 0, 2'd0};
    vecs[8]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd9, 5'd9, 0, 1, 0, 5'd5, 64'h1234, 1, 1, 2'd2};
    vecs[9]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd9, 5'd9, 1, 1, 1, 5'd9, 64'hB,    1, 1, 2'd2};
    vecs[10] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd9, 5'd9, 1, 1, 1, 5'd9, 64'hA,    1, 1, 2'd1};
    vecs[11] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd9, 5'd9, 1, 1, 0, 5'd9, 64'hA,    0, 0, 2'd0};
    vecs[12] = '{0, 5'd0, 64'h0,    1, 5'd4, 64'h44, 5'd4, 5'd0, 1, 1, 0, 5'd9, 64'hA,    0, 0, 2'd0};
    vecs[13] = '{1, 5'd4, 64'h55,   0, 5'd0, 64'h0,  5'd4, 5'd0, 1, 1, 0, 5'd9, 64'hA,    1, 0, 2'd1};
    vecs[14] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd4, 5'd0, 1, 1, 1, 5'd4, 64'h44,   1, 0, 2'd2};
    vecs[15] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd4, 5'd0, 1, 1, 1, 5'd4, 64'h55,   1, 0, 2'd1};
    vecs[16] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  5'd4, 5'd0, 1, 1, 0, 5'd4, 64'h55,   0, 0, 2'd0};

    drive_idle();
    raddr1_i = 5'd1;
    raddr2_i = 5'd2;
    rst = 1'b0;
    #12;
    check_quiet("reset");

    @(negedge clk);
    rst = 1'b1;

    // Table-driven single writes, x0 discard, same-register ordering.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      exu_valid_i = vecs[i].ev;
      exu_waddr_i = vecs[i].ea;
      exu_wdata_i = vecs[i].ed;
      lsu_valid_i = vecs[i].lv;
      lsu_waddr_i = vecs[i].la;
      lsu_wdata_i = vecs[i].ld;
      raddr1_i    = vecs[i].r1;
      raddr2_i    = vecs[i].r2;
      #1;
      check($sformatf("vec%0d eready", i),  64'(exu_ready_o), 64'(vecs[i].x_er));
      check($sformatf("vec%0d lready", i),  64'(lsu_ready_o), 64'(vecs[i].x_lr));
      check($sformatf("vec%0d we", i),      64'(we_o),        64'(vecs[i].x_we));
      check($sformatf("vec%0d waddr", i),   64'(waddr_o),     64'(vecs[i].x_wa));
      check($sformatf("vec%0d wdata", i),   wdata_o,          vecs[i].x_wd);
      check($sformatf("vec%0d hz1", i),     64'(hazard1_o),   64'(vecs[i].x_h1));
      check($sformatf("vec%0d hz2", i),     64'(hazard2_o),   64'(vecs[i].x_h2));
      check($sformatf("vec%0d pending", i), 64'(pending_o),   64'(vecs[i].x_pend));
    end

    // Sustained contention: 4 EXU writes to x3 and 4 LSU writes to x7, each
    // source holding valid until all its requests are accepted. Expected
    // order alternates E0,L0,E1,L1,... in 8 consecutive write cycles.
    begin
      int e_idx = 0;
      int l_idx = 0;
      int wr_cnt = 0;
      int first_we = -1;
      int last_we = -1;
      logic e_fire;
      logic l_fire;
      logic [4:0]  exp_a;
      logic [63:0] exp_d;
      @(negedge clk);
      raddr1_i = 5'd0;
      raddr2_i = 5'd0;
      for (int c = 0; c < 40 && wr_cnt < 8; c++) begin
        exu_valid_i = (e_idx < 4);
        exu_waddr_i = 5'd3;
        exu_wdata_i = 64'hE0 + 64'(e_idx);
        lsu_valid_i = (l_idx < 4);
        lsu_waddr_i = 5'd7;
        lsu_wdata_i = 64'h70 + 64'(l_idx);
        #1;
        if (c >= 1 && c <= 7) begin
          check($sformatf("rr c%0d eready", c), 64'(exu_ready_o), 64'(c % 2 == 1));
          check($sformatf("rr c%0d lready", c), 64'(lsu_ready_o), 64'(c % 2 == 0));
        end
        if (we_o) begin
          exp_a = (wr_cnt % 2 == 0) ? 5'd3 : 5'd7;
          exp_d = (wr_cnt % 2 == 0) ? 64'hE0 + 64'(wr_cnt / 2) : 64'h70 + 64'(wr_cnt / 2);
          check($sformatf("rr wr%0d waddr", wr_cnt), 64'(waddr_o), 64'(exp_a));
          check($sformatf("rr wr%0d wdata", wr_cnt), wdata_o, exp_d);
          if (first_we < 0) first_we = c;
          last_we = c;
          wr_cnt++;
        end
        e_fire = exu_valid_i & exu_ready_o;
        l_fire = lsu_valid_i & lsu_ready_o;
        @(negedge clk);
        if (e_fire) e_idx++;
        if (l_fire) l_idx++;
      end
      drive_idle();
      check("rr write count", 64'(wr_cnt), 64'd8);
      check("rr consecutive", 64'(last_we - first_we), 64'd7);
      #1;
      check("rr drained we", 64'(we_o), 64'd0);
      check("rr drained pending", 64'(pending_o), 64'd0);
    end

    // Mid-stream reset with both buffers full and a write in the output stage.
    @(negedge clk);
    exu_valid_i = 1'b1; exu_waddr_i = 5'd1; exu_wdata_i = 64'h111;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd2; lsu_wdata_i = 64'h222;
    @(negedge clk);
    exu_waddr_i = 5'd1; exu_wdata_i = 64'h333;
    @(negedge clk);
    raddr1_i = 5'd1;
    raddr2_i = 5'd2;
    #1;
    check("pre-reset pending", 64'(pending_o), 64'd3);
    #1;
    rst = 1'b0;
    #1;
    check_quiet("midreset");
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("post-reset c%0d we", c), 64'(we_o), 64'd0);
      check($sformatf("post-reset c%0d pending", c), 64'(pending_o), 64'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
